multiplier_8x8: RTL and testbench

MULTIPLIER_8X8 -- requirements
Module: multiplier_8x8

---
 rtl/multiplier_8x8.sv | 91 +++++++++
 tb/tb_multiplier_8x8.sv | 128 ++++++++++++
 2 files changed

// File: rtl/multiplier_8x8.sv
// Sequential radix-2 shift-and-add 8x8 unsigned multiplier.
// areset both clears the result and captures A/B to start a new multiply.
module multiplier_8x8 (
  input  logic        clk,
  input  logic        areset,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] product
);

  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned STEPS = 8;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [OP_W-1:0]  mcand;
  logic [OP_W-1:0]  mplier;
  logic [RES_W-1:0] acc;
  logic [CNT_W-1:0] count;

  logic             step_c;
  logic             last_c;
  logic [RES_W-1:0] addend_c;
  logic [RES_W-1:0] sum_c;

  // State register; areset restarts the multiply from any state
  always_ff @(posedge clk) begin
    if (areset) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and step control
  always_comb begin
    state_n = state;
    step_c  = 1'b0;
    last_c  = 1'b0;
    unique case (state)
      LOAD: state_n = LOAD;
      RUN: begin
        step_c = 1'b1;
        if (count == LAST_STEP) begin
          last_c  = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = DONE;
      default: state_n = LOAD;
    endcase
  end

  // Partial product for this step; 16-bit add keeps every carry
  always_comb begin
    addend_c = '0;
    if (mplier[0]) begin
      addend_c = RES_W'(mcand) << count;
    end
    sum_c = acc + addend_c;
  end

  // Datapath and result register
  always_ff @(posedge clk) begin
    if (areset) begin
      mcand   <= A;
      mplier  <= B;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else if (step_c) begin
      acc    <= sum_c;
      mplier <= mplier >> 1;
      count  <= count + CNT_W'(1);
      if (last_c) begin
        product <= sum_c;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_8x8.sv
// Self-checking bench for multiplier_8x8: directed vector table, corner
// sequences (mid-run restart, held reset) and random operands vs A*B.
module tb_multiplier_8x8;

  logic        clk;
  logic        areset;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] product;

  int passed;
  int total;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    logic        scramble;
  } vec_t;

  vec_t vecs[7];

  multiplier_8x8 dut (
    .clk     (clk),
    .areset  (areset),
    .A       (A),
    .B       (B),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: product=%0d (0x%04h) expected=%0d (0x%04h) at %0t",
               name, act, act, exp, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Drive areset high with operands for the next rising edge
  task automatic start(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    areset = 1'b1;
    A = a;
    B = b;
  endtask

  // Release reset, check zeros through edges 0..7, result at 8, then hold
  task automatic follow(input string name, input logic [15:0] exp,
                        input logic scramble, input int hold);
    @(negedge clk);
    areset = 1'b0;
    check({name, " reset edge"}, product, 16'd0);
    for (int k = 1; k <= 8 + hold; k++) begin
      if (scramble) begin
        A = 8'($urandom);
        B = 8'($urandom);
      end
      @(negedge clk);
      if (k < 8) check({name, " pre-result"}, product, 16'd0);
      else       check({name, " result"}, product, exp);
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    areset = 1'b0;
    A      = '0;
    B      = '0;

    vecs[0] = '{a: 8'd255, b: 8'd100, exp: 16'd25500, scramble: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'hFE01,  scramble: 1'b0};
    vecs[2] = '{a: 8'd1,   b: 8'd1,   exp: 16'd1,     scramble: 1'b0};
    vecs[3] = '{a: 8'd0,   b: 8'd200, exp: 16'd0,     scramble: 1'b0};
    vecs[4] = '{a: 8'd200, b: 8'd0,   exp: 16'd0,     scramble: 1'b0};
    vecs[5] = '{a: 8'd255, b: 8'd100, exp: 16'd25500, scramble: 1'b1};
    vecs[6] = '{a: 8'd128, b: 8'd128, exp: 16'h4000,  scramble: 1'b1};

    for (int i = 0; i < 7; i++) begin
      start(vecs[i].a, vecs[i].b);
      follow($sformatf("vec%0d", i), vecs[i].exp, vecs[i].scramble, 3);
    end

    // Restart mid-run: 255*100 discarded, 12*13 reported 8 edges later
    start(8'd255, 8'd100);
    @(negedge clk);
    areset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrun pre-restart", product, 16'd0);
    end
    start(8'd12, 8'd13);
    follow("midrun restart", 16'd156, 1'b0, 2);

    // Held reset: reload every edge, only the last operands count
    start(8'd9, 8'd9);
    start(8'd50, 8'd60);
    check("held reset 1", product, 16'd0);
    start(8'd20, 8'd30);
    check("held reset 2", product, 16'd0);
    follow("held reset", 16'd600, 1'b0, 1);

    // Random operands against arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      start(ra, rb);
      follow("random", ref_mul(ra, rb), i[0], 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
